// File: rtl/ltssm_os_decoder.sv
// Per-lane receive ordered-set decoder: finds TS1/TS2, SKP and logical Idle in the
// descrambled, symbol-aligned 8b/10b stream and registers the training fields per lane.
module ltssm_os_decoder_lane #(
    parameter int IDLE_CNT = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_en,
    input  logic       i_vld,
    input  logic [7:0] i_data,
    input  logic       i_k,
    output logic       o_ts1,
    output logic       o_ts2,
    output logic       o_err,
    output logic       o_idle,
    output logic [7:0] o_link,
    output logic [7:0] o_lane,
    output logic [7:0] o_nfts,
    output logic [7:0] o_rate,
    output logic [7:0] o_tctl,
    output logic       o_link_pad,
    output logic       o_lane_pad
);
    localparam int CW = $clog2(IDLE_CNT + 1);
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_TS2 = 8'h45;
    localparam logic [7:0] SYM_IDL = 8'h00;

    logic [0:0]    r_state;
    logic [3:0]    r_idx;
    logic          r_is_ts2;
    logic [7:0]    r_sh_link, r_sh_lane, r_sh_nfts, r_sh_rate, r_sh_tctl;
    logic          r_sh_link_pad, r_sh_lane_pad;
    logic [CW-1:0] r_idle_cnt;
    logic          r_ts1, r_ts2, r_err;
    logic [7:0]    r_link, r_lane, r_nfts, r_rate, r_tctl;
    logic          r_link_pad, r_lane_pad;

    logic w_d, w_com, w_pad, w_skp, w_sym_ok;

    assign w_d   = !i_k;
    assign w_com = i_k && (i_data == SYM_COM);
    assign w_pad = i_k && (i_data == SYM_PAD);
    assign w_skp = i_k && (i_data == SYM_SKP);

    // Link and lane may carry PAD; everything after must be data, and the
    // identifier chosen at index 6 must repeat through index 15.
    always_comb begin
        w_sym_ok = 1'b0;
        case (r_idx)
            4'd1, 4'd2:       w_sym_ok = w_d || w_pad;
            4'd3, 4'd4, 4'd5: w_sym_ok = w_d;
            4'd6:             w_sym_ok = w_d && (i_data == SYM_TS1 || i_data == SYM_TS2);
            default:          w_sym_ok = w_d && (i_data == (r_is_ts2 ? SYM_TS2 : SYM_TS1));
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_HUNT;
            r_idx         <= '0;
            r_is_ts2      <= 1'b0;
            r_sh_link     <= '0;
            r_sh_lane     <= '0;
            r_sh_nfts     <= '0;
            r_sh_rate     <= '0;
            r_sh_tctl     <= '0;
            r_sh_link_pad <= 1'b0;
            r_sh_lane_pad <= 1'b0;
            r_idle_cnt    <= '0;
            r_ts1         <= 1'b0;
            r_ts2         <= 1'b0;
            r_err         <= 1'b0;
            r_link        <= '0;
            r_lane        <= '0;
            r_nfts        <= '0;
            r_rate        <= '0;
            r_tctl        <= '0;
            r_link_pad    <= 1'b0;
            r_lane_pad    <= 1'b0;
        end else begin
            r_ts1 <= 1'b0;
            r_ts2 <= 1'b0;
            r_err <= 1'b0;
            if (!i_en) begin
                r_state    <= ST_HUNT;
                r_idx      <= '0;
                r_idle_cnt <= '0;
            end else if (i_vld) begin
                // SKP ordered sets (COM + SKPs) must not break an Idle run.
                if (w_d && i_data == SYM_IDL) begin
                    if (r_idle_cnt != CW'(IDLE_CNT)) r_idle_cnt <= r_idle_cnt + CW'(1);
                end else if (!(w_com || w_skp)) begin
                    r_idle_cnt <= '0;
                end

                case (r_state)
                    ST_HUNT: begin
                        if (w_com) begin
                            r_state <= ST_BODY;
                            r_idx   <= 4'd1;
                        end
                    end
                    default: begin
                        if (r_idx == 4'd1 && w_skp) begin
                            r_state <= ST_HUNT;
                        end else if (w_sym_ok) begin
                            case (r_idx)
                                4'd1: begin r_sh_link <= i_data; r_sh_link_pad <= w_pad; end
                                4'd2: begin r_sh_lane <= i_data; r_sh_lane_pad <= w_pad; end
                                4'd3: r_sh_nfts <= i_data;
                                4'd4: r_sh_rate <= i_data;
                                4'd5: r_sh_tctl <= i_data;
                                4'd6: r_is_ts2  <= (i_data == SYM_TS2);
                                default: ;
                            endcase
                            if (r_idx == 4'd15) begin
                                r_link     <= r_sh_link;
                                r_lane     <= r_sh_lane;
                                r_nfts     <= r_sh_nfts;
                                r_rate     <= r_sh_rate;
                                r_tctl     <= r_sh_tctl;
                                r_link_pad <= r_sh_link_pad;
                                r_lane_pad <= r_sh_lane_pad;
                                r_ts1      <= !r_is_ts2;
                                r_ts2      <= r_is_ts2;
                                r_state    <= ST_HUNT;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end else begin
                            // A stray COM is taken as the start of a new set.
                            r_err <= 1'b1;
                            if (w_com) r_idx   <= 4'd1;
                            else       r_state <= ST_HUNT;
                        end
                    end
                endcase
            end
        end
    end

    assign o_ts1      = r_ts1;
    assign o_ts2      = r_ts2;
    assign o_err      = r_err;
    assign o_idle     = (r_idle_cnt == CW'(IDLE_CNT));
    assign o_link     = r_link;
    assign o_lane     = r_lane;
    assign o_nfts     = r_nfts;
    assign o_rate     = r_rate;
    assign o_tctl     = r_tctl;
    assign o_link_pad = r_link_pad;
    assign o_lane_pad = r_lane_pad;
endmodule

module ltssm_os_decoder #(
    parameter int MAX_NUM_LANES = 4,
    parameter int IDLE_CNT      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [MAX_NUM_LANES*8-1:0] s_axis_tdata,
    input  logic [MAX_NUM_LANES-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [MAX_NUM_LANES-1:0]   ts1_valid_o,
    output logic [MAX_NUM_LANES-1:0]   ts2_valid_o,
    output logic [MAX_NUM_LANES-1:0]   idle_valid_o,
    output logic [MAX_NUM_LANES*8-1:0] link_num_o,
    output logic [MAX_NUM_LANES*8-1:0] lane_num_o,
    output logic [MAX_NUM_LANES*8-1:0] n_fts_o,
    output logic [MAX_NUM_LANES*8-1:0] rate_id_o,
    output logic [MAX_NUM_LANES*8-1:0] training_ctrl_o,
    output logic [MAX_NUM_LANES-1:0]   link_pad_o,
    output logic [MAX_NUM_LANES-1:0]   lane_pad_o,
    output logic [MAX_NUM_LANES-1:0]   os_error_o
);
    assign s_axis_tready = rst_ni;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
        ltssm_os_decoder_lane #(.IDLE_CNT(IDLE_CNT)) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .i_en       (en_i),
            .i_vld      (s_axis_tvalid),
            .i_data     (s_axis_tdata[8*g +: 8]),
            .i_k        (s_axis_tuser[g]),
            .o_ts1      (ts1_valid_o[g]),
            .o_ts2      (ts2_valid_o[g]),
            .o_err      (os_error_o[g]),
            .o_idle     (idle_valid_o[g]),
            .o_link     (link_num_o[8*g +: 8]),
            .o_lane     (lane_num_o[8*g +: 8]),
            .o_nfts     (n_fts_o[8*g +: 8]),
            .o_rate     (rate_id_o[8*g +: 8]),
            .o_tctl     (training_ctrl_o[8*g +: 8]),
            .o_link_pad (link_pad_o[g]),
            .o_lane_pad (lane_pad_o[g])
        );
    end
endmodule

// File: tb/tb_ltssm_os_decoder.sv
// Self-checking bench for ltssm_os_decoder: per-beat expectations go through a
// scoreboard queue and are compared one cycle after the beat is driven.
module tb_ltssm_os_decoder;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tuser = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [3:0]  ts1_valid_o, ts2_valid_o, idle_valid_o, link_pad_o, lane_pad_o, os_error_o;
    logic [31:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, training_ctrl_o;

    ltssm_os_decoder #(.MAX_NUM_LANES(4), .IDLE_CNT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .ts1_valid_o(ts1_valid_o), .ts2_valid_o(ts2_valid_o), .idle_valid_o(idle_valid_o),
        .link_num_o(link_num_o), .lane_num_o(lane_num_o), .n_fts_o(n_fts_o),
        .rate_id_o(rate_id_o), .training_ctrl_o(training_ctrl_o),
        .link_pad_o(link_pad_o), .lane_pad_o(lane_pad_o), .os_error_o(os_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  ts1, ts2, err, idle;
        bit          ci;
    } vec_t;

    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic vld, input logic [7:0] b,
                                input logic kb, input bit all, input logic [3:0] ts1,
                                input logic [3:0] ts2, input logic [3:0] err,
                                input logic [3:0] idle, input bit ci);
        vec_t v;
        v.en = en; v.vld = vld;
        v.d  = all ? {4{b}} : {24'hFFFFFF, b};
        v.k  = all ? {4{kb}} : {3'b000, kb};
        v.ts1 = ts1; v.ts2 = ts2; v.err = err; v.idle = idle; v.ci = ci;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk_i);
        en_i = v.en; s_axis_tvalid = v.vld; s_axis_tdata = v.d; s_axis_tuser = v.k;
        sb.push_back(v);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk("ts1_valid", ts1_valid_o, e.ts1);
        chk("ts2_valid", ts2_valid_o, e.ts2);
        chk("os_error", os_error_o, e.err);
        if (e.ci) chk("idle_valid", idle_valid_o, e.idle);
    endtask

    task automatic beat(input logic [7:0] b, input logic kb, input bit all,
                        input logic [3:0] ts1, input logic [3:0] ts2, input logic [3:0] err);
        apply(mk(1'b1, 1'b1, b, kb, all, ts1, ts2, err, 4'h0, 1'b0));
    endtask

    function automatic logic [7:0] ts_sym(input int idx, input logic [7:0] link, input logic [7:0] lane,
                                          input logic [7:0] nfts, input logic [7:0] rate,
                                          input logic [7:0] tctl, input logic [7:0] id);
        case (idx)
            0: return 8'hBC;
            1: return link;
            2: return lane;
            3: return nfts;
            4: return rate;
            5: return tctl;
            default: return id;
        endcase
    endfunction

    function automatic logic ts_k(input int idx, input logic [7:0] sym);
        return (idx == 0) || ((idx == 1 || idx == 2) && sym == 8'hF7);
    endfunction

    task automatic send_ts(input bit all, input logic [7:0] link, input logic [7:0] lane,
                           input logic [7:0] nfts, input logic [7:0] rate,
                           input logic [7:0] tctl, input logic [7:0] id, input logic [3:0] m);
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            s = ts_sym(i, link, lane, nfts, rate, tctl, id);
            beat(s, ts_k(i, s), all, (i == 15 && id == 8'h4A) ? m : 4'h0,
                 (i == 15 && id == 8'h45) ? m : 4'h0, 4'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[16];
        logic [7:0] s;

        for (int i = 0; i < 16; i++) begin
            s = ts_sym(i, 8'h00, 8'h00, 8'h1F, 8'h02, 8'h00, 8'h4A);
            tbl[i] = mk(1'b1, 1'b1, s, ts_k(i, s), 1'b0, (i == 15) ? 4'h1 : 4'h0,
                        4'h0, 4'h0, 4'h0, 1'b0);
        end

        // Reset state
        #12;
        chk("tready_in_reset", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_ts1", ts1_valid_o, 32'd0);
        chk("rst_idle", idle_valid_o, 32'd0);
        chk("rst_link", link_num_o, 32'd0);
        chk("rst_err", os_error_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("tready_out_of_reset", {31'd0, s_axis_tready}, 32'd1);

        // Single-lane TS1 from table
        for (int i = 0; i < 16; i++) apply(tbl[i]);
        chk("t1_link", link_num_o, 32'h0000_0000);
        chk("t1_lane", lane_num_o, 32'h0000_0000);
        chk("t1_nfts", n_fts_o, 32'h0000_001F);
        chk("t1_rate", rate_id_o, 32'h0000_0002);
        chk("t1_link_pad", link_pad_o, 32'h0);

        // All lanes TS2, link PAD, lane numbers 0..3
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            case (i)
                0: begin d = 32'hBCBCBCBC; k = 4'hF; end
                1: begin d = 32'hF7F7F7F7; k = 4'hF; end
                2: begin d = 32'h03020100; k = 4'h0; end
                3: begin d = 32'h10101010; k = 4'h0; end
                4: begin d = 32'h02020202; k = 4'h0; end
                5: begin d = 32'h00000000; k = 4'h0; end
                default: begin d = 32'h45454545; k = 4'h0; end
            endcase
            apply('{en: 1'b1, vld: 1'b1, d: d, k: k, ts1: 4'h0,
                    ts2: (i == 15) ? 4'hF : 4'h0, err: 4'h0, idle: 4'h0, ci: 1'b0});
        end
        chk("t2_link", link_num_o, 32'hF7F7F7F7);
        chk("t2_link_pad", link_pad_o, 32'hF);
        chk("t2_lane_pad", lane_pad_o, 32'h0);
        chk("t2_lane", lane_num_o, 32'h03020100);
        chk("t2_nfts", n_fts_o, 32'h10101010);

        // TS1 with a bad identifier at symbol 9, then a good TS1
        for (int i = 0; i < 16; i++) begin
            s = (i == 9) ? 8'h45 : ts_sym(i, 8'h05, 8'h01, 8'h22, 8'h02, 8'h00, 8'h4A);
            beat(s, ts_k(i, s), 1'b0, 4'h0, 4'h0, (i == 9) ? 4'h1 : 4'h0);
        end
        chk("bad_keeps_link", link_num_o, 32'hF7F7F7F7);
        send_ts(1'b0, 8'h05, 8'h01, 8'h22, 8'h02, 8'h00, 8'h4A, 4'h1);
        chk("good_link", link_num_o, 32'hF7F7F705);
        chk("good_link_pad", link_pad_o, 32'hE);
        chk("good_nfts", n_fts_o, 32'h10101022);

        // COM injected at index 7 restarts the set as a TS2
        for (int i = 0; i < 7; i++) begin
            s = ts_sym(i, 8'h06, 8'h02, 8'h33, 8'h02, 8'h00, 8'h4A);
            beat(s, ts_k(i, s), 1'b0, 4'h0, 4'h0, 4'h0);
        end
        beat(8'hBC, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1);
        for (int i = 1; i < 16; i++) begin
            s = ts_sym(i, 8'h09, 8'h03, 8'h44, 8'h01, 8'h08, 8'h45);
            beat(s, ts_k(i, s), 1'b0, 4'h0, (i == 15) ? 4'h1 : 4'h0, 4'h0);
        end
        chk("resync_link", link_num_o, 32'hF7F7F709);
        chk("resync_tctl", training_ctrl_o, 32'h00000008);

        // Idle run across a SKP ordered set, saturation, then clear
        for (int i = 0; i < 7; i++) apply(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 4'h0, 1));
        apply(mk(1, 1, 8'hBC, 1, 1, 0, 0, 0, 4'h0, 1));
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 8'h1C, 1, 1, 0, 0, 0, 4'h0, 1));
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 4'hF, 1));
        apply(mk(1, 1, 8'h4A, 0, 1, 0, 0, 0, 4'h0, 1));

        // tvalid toggled every other cycle during a TS1
        for (int i = 0; i < 16; i++) begin
            apply(mk(1, 0, 8'hBC, 1, 0, 0, 0, 0, 4'h0, 0));
            s = ts_sym(i, 8'h07, 8'h00, 8'h20, 8'h02, 8'h00, 8'h4A);
            beat(s, ts_k(i, s), 1'b0, (i == 15) ? 4'h1 : 4'h0, 4'h0, 4'h0);
        end
        chk("stall_link", link_num_o, 32'hF7F7F707);

        // en_i dropped mid-set: no error, no pulse, fields held
        for (int i = 0; i < 6; i++) begin
            s = ts_sym(i, 8'h0A, 8'h00, 8'h20, 8'h02, 8'h00, 8'h4A);
            beat(s, ts_k(i, s), 1'b0, 4'h0, 4'h0, 4'h0);
        end
        apply(mk(0, 1, 8'h4A, 0, 0, 0, 0, 0, 4'h0, 0));
        for (int i = 6; i < 16; i++) beat(8'h4A, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("en_drop_link", link_num_o, 32'hF7F7F707);

        // en_i low clears the idle counters
        for (int i = 0; i < 8; i++) apply(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, (i == 7) ? 4'hF : 4'h0, 1));
        apply(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 4'h0, 1));

        // Reset asserted at index 10
        for (int i = 0; i < 11; i++) begin
            s = ts_sym(i, 8'h0B, 8'h00, 8'h20, 8'h02, 8'h00, 8'h4A);
            beat(s, ts_k(i, s), 1'b0, 4'h0, 4'h0, 4'h0);
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("mid_rst_ts1", ts1_valid_o, 32'd0);
        chk("mid_rst_link", link_num_o, 32'd0);
        chk("mid_rst_lane", lane_num_o, 32'd0);
        chk("mid_rst_nfts", n_fts_o, 32'd0);
        chk("mid_rst_rate", rate_id_o, 32'd0);
        chk("mid_rst_tctl", training_ctrl_o, 32'd0);
        chk("mid_rst_pads", {link_pad_o, lane_pad_o}, 32'd0);
        chk("mid_rst_err_idle", {os_error_o, idle_valid_o, ts2_valid_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 11; i < 16; i++) beat(8'h4A, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("post_rst_link", link_num_o, 32'd0);
        send_ts(1'b0, 8'h0C, 8'h00, 8'h2A, 8'h02, 8'h01, 8'h4A, 4'h1);
        chk("post_rst_good_link", link_num_o, 32'h0000000C);
        chk("post_rst_good_nfts", n_fts_o, 32'h0000002A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ltssm_os_decoder.md
# ltssm_os_decoder

Per-lane receive-side ordered-set decoder for the Gen1/Gen2 (8b/10b) PHY. It parses the descrambled, symbol-aligned receive stream from the lane deskew stage and recognises TS1 and TS2 ordered sets, SKP ordered sets and logical Idle. For each lane it produces the registered `ts1_valid`, `ts2_valid`, `idle_valid`, link/lane number, rate ID and training-control fields that the LTSSM detect, polling, configuration and recovery blocks consume. It is the receive counterpart of the LTSSM ordered-set transmit path.

## Interface
Parameters:
- `MAX_NUM_LANES`, default 4: number of lanes decoded in parallel.
- `IDLE_CNT`, default 8: number of consecutive Idle data symbols required for `idle_valid_o`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `en_i`  in  1  decoder enable.
- `s_axis_tdata`  in  MAX_NUM_LANES*8  one symbol per lane; lane n is at [8n+7:8n].
- `s_axis_tuser`  in  MAX_NUM_LANES  per-lane K-symbol flag.
- `s_axis_tvalid`  in  1  symbol beat valid.
- `s_axis_tready`  out  1  0 while in reset, 1 otherwise.
- `ts1_valid_o`  out  MAX_NUM_LANES  one-cycle pulse per valid TS1.
- `ts2_valid_o`  out  MAX_NUM_LANES  one-cycle pulse per valid TS2.
- `idle_valid_o`  out  MAX_NUM_LANES  level output, high when IDLE_CNT consecutive Idle symbols have been seen.
- `link_num_o`  out  MAX_NUM_LANES*8  symbol 1 of the last valid TS; PAD is reported as 8'hF7.
- `lane_num_o`  out  MAX_NUM_LANES*8  symbol 2 of the last valid TS.
- `n_fts_o`  out  MAX_NUM_LANES*8  symbol 3 of the last valid TS.
- `rate_id_o`  out  MAX_NUM_LANES*8  symbol 4 of the last valid TS.
- `training_ctrl_o`  out  MAX_NUM_LANES*8  symbol 5 of the last valid TS.
- `link_pad_o`  out  MAX_NUM_LANES  symbol 1 of the last valid TS was PAD.
- `lane_pad_o`  out  MAX_NUM_LANES  symbol 2 of the last valid TS was PAD.
- `os_error_o`  out  MAX_NUM_LANES  one-cycle pulse when an ordered set is malformed.

## Operation
- Each lane runs an independent FSM with states ST_HUNT and ST_BODY, plus a 4-bit symbol index and a shadow field register.
- Symbol encodings:
  - COM is K, 8'hBC.
  - PAD is K, 8'hF7.
  - SKP is K, 8'h1C.
  - The TS1 identifier is D, 8'h4A.
  - The TS2 identifier is D, 8'h45.
  - Idle is D, 8'h00.
- A beat is processed only when `s_axis_tvalid` && `en_i`.
- ST_HUNT:
  - COM → ST_BODY, index=1.
  - All other symbols are ignored.
- ST_BODY, by index:
  - Index 1: SKP → ST_HUNT silently (this is a SKP ordered set). Otherwise the symbol must be a D symbol or PAD; capture it as link.
  - Index 2: must be a D symbol or PAD; capture it as lane.
  - Index 3–5: must be D symbols; capture them as n_fts, rate_id and training_ctrl.
  - Index 6: must be D 4A or D 45; latch the type.
  - Index 7–15: must equal the latched identifier.
  - Index 15 accepted → commit the shadow fields to the outputs, pulse ts1/ts2_valid, return to ST_HUNT.
- Any violation in ST_BODY:
  - Pulse `os_error_o` and discard the shadow fields.
  - If the offending symbol is COM → restart at index=1 (re-sync).
  - Otherwise → ST_HUNT.
- Idle counter, per lane, saturating at IDLE_CNT:
  - Increments on each D 00 symbol.
  - Holds on COM and SKP.
  - Clears on any other symbol.
  - `idle_valid_o` = (count == IDLE_CNT).
- `en_i` low:
  - All lanes forced to ST_HUNT.
  - Idle counters cleared.
  - Pulses suppressed.
  - Field outputs hold their last values.
- Lanes never interact; lanes outside the active width are simply idle.

## Timing
- Reset values of all outputs are 0, except `s_axis_tready`=0 while `rst_ni` is low.
- TS valid pulse: `ts*_valid_o` is high for exactly 1 cycle, in the cycle after symbol 15 is accepted.
- Field outputs update in that same cycle and are stable until the next valid TS.
- `os_error_o` is high in the cycle after the offending symbol.
- `idle_valid_o` rises in the cycle after the IDLE_CNT-th Idle symbol. It falls in the cycle after the first clearing symbol.
- `s_axis_tvalid` low stalls all lane FSMs and counters; no state changes.
- Back-to-back TS sets with no gap produce valid pulses 16 cycles apart.
- Reset mid-ordered-set: the partial ordered set is discarded and the lane restarts in ST_HUNT.
- `en_i` deasserted mid-set: the set is dropped with no error pulse.

## Test plan
- Lane 0 receives COM, 8'h00, 8'h00, 8'h1F, 8'h02, 8'h00, then 10×4A → `ts1_valid_o[0]` pulses once at cycle 17; link=0, lane=0, n_fts=8'h1F, rate=8'h02.
- All 4 lanes receive TS2 with link PAD and lanes 0–3 → `ts2_valid_o`=4'hF; `link_pad_o`=4'hF; `lane_num_o`=32'h03020100.
- TS1 with symbol 9 = 8'h45 → `os_error_o[0]` pulses and there is no valid pulse. A following good TS1 decodes normally.
- COM injected at index 7, followed by a full TS2 → one error pulse, then `ts2_valid_o` pulses 15 beats after the injected COM.
- 7 Idle symbols, a SKP ordered set (COM plus 3×SKP), then 1 Idle → `idle_valid_o` rises only after the 8th Idle. A subsequent D 4A symbol clears it.
- `s_axis_tvalid` toggled 50% during a TS1 → exactly one `ts1_valid_o` pulse, after the 16th accepted beat. `rst_ni` asserted at index 10 → no pulse, and all outputs are 0.
